// File: rtl/path_replayer_pkg.sv
// -----------------------------------------------------------------------------
// path_replayer_pkg
// Shared types and constants for the path replayer.
//   loc_t   : 8-bit maze location {X[7:4], Y[3:0]}
//   dir_t   : 2-bit move direction code
//   state_t : replayer FSM state code, with ST_* constants
// sat_inc8() is an 8-bit increment that sticks at 8'hFF.
// -----------------------------------------------------------------------------
package path_replayer_pkg;

    typedef logic [7:0] loc_t;
    typedef logic [1:0] dir_t;
    typedef logic [2:0] state_t;

    // Direction encodings. An X move is selected when dir[1]^dir[0] is set,
    // and dir[0] selects the +1 step.
    localparam dir_t DIR_YDEC = 2'b00;
    localparam dir_t DIR_XINC = 2'b01;
    localparam dir_t DIR_XDEC = 2'b10;
    localparam dir_t DIR_YINC = 2'b11;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_MOVE = 3'd1;
    localparam state_t ST_CHECK     = 3'd2;
    localparam state_t ST_DONE      = 3'd3;
    localparam state_t ST_FAIL      = 3'd4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/path_replayer_loc_step.sv
// -----------------------------------------------------------------------------
// loc_step
// Purely combinational single-step location calculator.
//   curLoc      in  : current location {X,Y}
//   dir         in  : move direction (see path_replayer_pkg DIR_*)
//   nxtLoc      out : location after the step (wraps if outOfBounds; the
//                     caller must not use it in that case)
//   outOfBounds out : step would leave the 16x16 grid
// -----------------------------------------------------------------------------
module loc_step
    import path_replayer_pkg::*;
(
    input  loc_t curLoc,
    input  dir_t dir,
    output loc_t nxtLoc,
    output logic outOfBounds
);

    logic       axis_x;
    logic       step_up;
    logic [1:0] sel_n;
    logic [1:0] oob_n;

    assign axis_x  = dir[1] ^ dir[0];
    assign step_up = dir[0];

    // Nibble 0 is Y, nibble 1 is X; only the selected nibble moves.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nib
            logic [3:0] nib;
            assign nib       = curLoc[gi*4 +: 4];
            assign sel_n[gi] = (gi == 1) ? axis_x : ~axis_x;
            assign oob_n[gi] = sel_n[gi] & (step_up ? (nib == 4'hF) : (nib == 4'h0));
            assign nxtLoc[gi*4 +: 4] = sel_n[gi] ? (step_up ? nib + 4'd1 : nib - 4'd1) : nib;
        end
    endgenerate

    assign outOfBounds = |oob_n;

endmodule

// File: rtl/path_replayer.sv
// -----------------------------------------------------------------------------
// path_replayer
// Replays a stream of moves through a 16x16 maze, checking each step against
// a 1-bit wall memory, and reports whether the path ends on GOAL_LOC.
// Parameters: GOAL_LOC, START_LOC (both {X[7:4],Y[3:0]}).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : pulse, begins a replay (ignored while busy)
//   moveIn/moveValid/lastMove, moveReady : move handshake
//   mazeRd/mazeAddr/mazeData : wall lookup, data one cycle after mazeRd
//   curLoc, busy, reached, fail, moveCnt : status
// Build option: define PATH_REPLAYER_MOVE_COUNT_EN to implement the saturating
// moveCnt counter; otherwise moveCnt is constant zero.
// -----------------------------------------------------------------------------
module path_replayer
    import path_replayer_pkg::*;
#(
    parameter logic [7:0] GOAL_LOC  = 8'hFF,
    parameter logic [7:0] START_LOC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] moveIn,
    input  logic       moveValid,
    input  logic       lastMove,
    output logic       moveReady,
    output logic       mazeRd,
    output logic [7:0] mazeAddr,
    input  logic       mazeData,
    output logic [7:0] curLoc,
    output logic       busy,
    output logic       reached,
    output logic       fail,
    output logic [7:0] moveCnt
);

    state_t state_reg, state_next;
    loc_t   cur_reg;
    loc_t   nxt_reg;
    logic   last_reg;

    loc_t   step_loc;
    logic   step_oob;
    logic   accept;
    logic   issue_rd;
    logic   restart;
    logic   commit;

    loc_step u_step (
        .curLoc      (cur_reg),
        .dir         (moveIn),
        .nxtLoc      (step_loc),
        .outOfBounds (step_oob)
    );

    assign accept   = (state_reg == ST_WAIT_MOVE) && moveValid;
    assign issue_rd = accept && !step_oob;
    assign restart  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                (state_reg == ST_FAIL));
    assign commit   = (state_reg == ST_CHECK) && !mazeData;

    assign moveReady = (state_reg == ST_WAIT_MOVE);
    assign busy      = (state_reg == ST_WAIT_MOVE) || (state_reg == ST_CHECK);
    assign reached   = (state_reg == ST_DONE);
    assign fail      = (state_reg == ST_FAIL);
    assign mazeRd    = issue_rd;
    assign mazeAddr  = issue_rd ? step_loc : cur_reg;
    assign curLoc    = cur_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) state_next = ST_WAIT_MOVE;
            end
            ST_WAIT_MOVE: begin
                // An off-grid step fails without touching the maze.
                if (accept) state_next = step_oob ? ST_FAIL : ST_CHECK;
            end
            ST_CHECK: begin
                if (mazeData)                 state_next = ST_FAIL;
                else if (!last_reg)           state_next = ST_WAIT_MOVE;
                else if (nxt_reg == GOAL_LOC) state_next = ST_DONE;
                else                          state_next = ST_FAIL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cur_reg   <= START_LOC;
            nxt_reg   <= START_LOC;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (restart)     cur_reg <= START_LOC;
            else if (commit) cur_reg <= nxt_reg;
            if (issue_rd) begin
                nxt_reg  <= step_loc;
                last_reg <= lastMove;
            end
        end
    end

`ifdef PATH_REPLAYER_MOVE_COUNT_EN
    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)         cnt_reg <= 8'h00;
        else if (restart) cnt_reg <= 8'h00;
        else if (commit)  cnt_reg <= sat_inc8(cnt_reg);
    end

    assign moveCnt = cnt_reg;
`else
    assign moveCnt = 8'h00;
`endif

endmodule
